sig_verify_scheduler: RTL and testbench
=======================================

# sig_verify_scheduler

Shares the single signature-verifier pipeline among N_REQ requesters. Each cycle, it picks one pending signature round-robin and drives it onto the verifier input. A tag pipeline tracks every in-flight signature, so the match result returns to the requester that issued it. It sits between the requesting agents and the verifier, and also provides enable/drain sequencing and saturating statistics counters.

## Interface
- N_REQ, default 4: number of requesters (2..8).
- MATCH_LATENCY, default 2: cycles from `vf_sig` change to `vf_match` valid for it.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  issue enable; deassertion starts a drain.
- req_valid  in  N_REQ  per-requester signature valid.
- req_sig  in  N_REQ*32  packed signatures; requester i uses bits [32i+31:32i].
- req_ready  out  N_REQ  one-hot grant; a handshake occurs when `req_valid[i] && req_ready[i]`.
- vf_sig  out  32  signature to verifier; registered.
- vf_match  in  1  verifier match result.
- rsp_valid  out  N_REQ  one-hot result strobe, 1 cycle.
- rsp_id  out  $clog2(N_REQ)  requester index of the result.
- rsp_match  out  1  match result.
- busy  out  1  state != IDLE.
- stat_clr  in  1  synchronous clear of statistics.
- stat_issued  out  16  handshakes accepted, saturating.
- stat_matched  out  16  results with match=1, saturating.

## Operation
- **FSM states:** IDLE, ACTIVE, DRAIN.
  - IDLE -> ACTIVE when `en` is high.
  - ACTIVE -> IDLE when `en` is low and nothing is in flight.
  - ACTIVE -> DRAIN when `en` is low and tags are in flight.
  - DRAIN -> IDLE when the tag pipeline is empty. `en` is ignored in DRAIN, so re-entry to ACTIVE goes through IDLE.
- **Arbitration:** round-robin starting after the last granted index. `req_ready` is combinational from `req_valid`, the pointer and state.
  - At most one bit of `req_ready` is set, and only in ACTIVE and only for a valid requester.
  - The pointer advances only on a handshake.
  - After reset, requester 0 has highest priority.
- **Issue:**
  - On a handshake, `vf_sig` <= the granted `req_sig` slice, and the tag {valid=1, id} enters stage 0 of the tag pipeline.
  - With no handshake, `vf_sig` <= 32'h0 and a null tag enters.
- **Tag pipeline:** depth 1+MATCH_LATENCY, shifting every cycle; "in flight" means any stage is valid.
  - When the tail tag is valid, the next edge registers `rsp_valid[id]`=1, `rsp_id`=id and `rsp_match`=`vf_match`.
  - Otherwise `rsp_valid` is 0 and `rsp_id`/`rsp_match` hold their last values.
- **Ordering and throughput:** results return in issue order; sustained throughput is one per cycle with no bubbles.
- **Statistics:**
  - `stat_issued` increments on each handshake.
  - `stat_matched` increments on each `rsp_valid` with `rsp_match`=1.
  - Both saturate at 16'hFFFF.
  - `stat_clr` sets both to 0 and wins over a same-cycle increment.

## Timing
- **Reset values:** all outputs 0, state IDLE, tags invalid, pointer=0.
- **Latency:** for a handshake at edge E0, `vf_sig` is valid in the cycle after E0, and `rsp_valid` is high in cycle 2+MATCH_LATENCY after E0 (cycle 4 for the default).
- **Disable timing:**
  - `en` falling in cycle t blocks handshakes in cycle t (ready is gated combinationally by the registered state).
  - Handshakes already accepted complete normally.
- **Reset mid-operation:** in-flight tags are discarded and no `rsp_valid` is produced for them.
- **Simultaneous events:** issue, result and `stat_clr` in the same cycle are all honored independently, with clear taking priority for the counters.

## Structure
- Package `sig_sched_pkg`:
  - state enum {IDLE, ACTIVE, DRAIN};
  - SIG_W=32, STAT_W=16;
  - tag struct {logic valid; logic [2:0] id}.
- Sub-module `rr_arbiter` (N-way round-robin, combinational grant plus a registered pointer updated on an `advance` input). The tag pipeline, FSM and counters stay in the top module.

## Test plan
- **Single request:** requester 2 sends 32'hA5031042 with a behavioral verifier (2-cycle latency, match iff sig==32'hA5031042). Required response: `vf_sig`=32'hA5031042 one cycle after the handshake; `rsp_valid`=4'b0100, `rsp_id`=2, `rsp_match`=1 in cycle 4; `stat_issued`=1, `stat_matched`=1.
- **Full contention:** all four requesters hold valid for 8 cycles. Required response: grants 0,1,2,3,0,1,2,3; responses arrive in the same order back-to-back; `stat_issued`=8.
- **Drain:** drop `en` with two tags in flight. Required response: `req_ready`=0 immediately; both responses delivered; `busy` falls the cycle after the last response; re-raising `en` during DRAIN has no effect until IDLE.
- **Reset mid-flight:** assert `rst` with three tags in flight and release. Required response: all outputs are 0 and no `rsp_valid` occurs afterwards.
- **Saturation and clear:** issue 65537 matching signatures. Required response: both counters stay at 16'hFFFF; `stat_clr` coincident with a handshake yields 0 the next cycle.
- **Fairness:** requester 0 valid continuously while requester 3 pulses valid. Required response: requester 3 is granted within 2 cycles of asserting valid and is never starved.

Source files
------------

// File: rtl/sig_sched_pkg.sv
// Shared types and helpers for the signature-verifier scheduler: FSM states,
// the in-flight tag record and the saturating counter step.
package sig_sched_pkg;

    localparam int SIG_W  = 32;
    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } tag_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/sig_verify_scheduler_if.sv
// Requester, verifier and result signals of the scheduler; the master side is
// the requesters plus the verifier, the slave side is the scheduler.
interface sig_verify_scheduler_if #(
    parameter int N_REQ = 4
) ();
    import sig_sched_pkg::*;

    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*SIG_W-1:0] req_sig;
    logic [N_REQ-1:0]       req_ready;
    logic [SIG_W-1:0]       vf_sig;
    logic                   vf_match;
    logic [N_REQ-1:0]       rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic                   rsp_match;

    modport master (
        output req_valid, req_sig, vf_match,
        input  req_ready, vf_sig, rsp_valid, rsp_id, rsp_match
    );

    modport slave (
        input  req_valid, req_sig, vf_match,
        output req_ready, vf_sig, rsp_valid, rsp_id, rsp_match
    );

endinterface

// File: rtl/sig_verify_scheduler_rr_arbiter.sv
// N-way round-robin arbiter: combinational one-hot grant, priority pointer
// moves to the slot after the winner whenever advance is asserted.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 advance,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr_r;
    logic          found_s;

    // Search from the pointer upward (wrapping) for the first valid requester.
    always_comb begin
        grant     = {N{1'b0}};
        grant_idx = {IW{1'b0}};
        found_s   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (enable && !found_s && req[(int'(ptr_r) + k) % N]) begin
                found_s   = 1'b1;
                grant_idx = IW'((int'(ptr_r) + k) % N);
            end else begin
                found_s   = found_s;
            end
        end
        if (found_s) begin
            grant = {{(N-1){1'b0}}, 1'b1} << grant_idx;
        end else begin
            grant = {N{1'b0}};
        end
    end

    // Priority pointer: the slot after the last winner becomes highest priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= {IW{1'b0}};
        end else if (advance) begin
            ptr_r <= (grant_idx == IW'(N - 1)) ? {IW{1'b0}} : grant_idx + IW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/sig_verify_scheduler.sv
// Shares one signature-verifier pipeline among N_REQ requesters, tagging each
// issued signature so its match result is routed back to the issuer.
module sig_verify_scheduler
    import sig_sched_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int MATCH_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  stat_clr,
    output logic                  busy,
    output logic [STAT_W-1:0]     stat_issued,
    output logic [STAT_W-1:0]     stat_matched,
    sig_verify_scheduler_if.slave bus
);
    localparam int ID_W = $clog2(N_REQ);

    state_t             state_r;
    state_t             state_next_s;
    logic [N_REQ-1:0]   grant_s;
    logic [ID_W-1:0]    grant_idx_s;
    logic               issue_ok_s;
    logic               hs_s;
    logic               inflight_s;
    logic [SIG_W-1:0]   sel_sig_s;
    tag_t               new_tag_s;
    tag_t               tail_s;
    tag_t               tags_r [MATCH_LATENCY+1];
    logic [SIG_W-1:0]   vf_sig_r;
    logic [N_REQ-1:0]   rsp_valid_r;
    logic [ID_W-1:0]    rsp_id_r;
    logic               rsp_match_r;
    logic               busy_r;
    logic [STAT_W-1:0]  issued_r;
    logic [STAT_W-1:0]  matched_r;

    // en gates grants in the same cycle it falls, not only after the state moves.
    assign issue_ok_s = (state_r == ACTIVE) && en;
    assign hs_s       = |grant_s;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .enable    (issue_ok_s),
        .advance   (hs_s),
        .req       (bus.req_valid),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    assign bus.req_ready = grant_s;
    assign bus.vf_sig    = vf_sig_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_match = rsp_match_r;
    assign busy          = busy_r;
    assign stat_issued   = issued_r;
    assign stat_matched  = matched_r;

    // Granted signature, new tag, pipeline tail and in-flight summary.
    always_comb begin
        sel_sig_s       = bus.req_sig[int'(grant_idx_s)*SIG_W +: SIG_W];
        new_tag_s.valid = hs_s;
        new_tag_s.id    = 3'(grant_idx_s);
        tail_s          = tags_r[MATCH_LATENCY];
        inflight_s      = 1'b0;
        for (int k = 0; k <= MATCH_LATENCY; k++) begin
            inflight_s = inflight_s | tags_r[k].valid;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; DRAIN ignores en so re-entry always passes through IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (en) begin
                    state_next_s = ACTIVE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACTIVE: begin
                if (!en) begin
                    state_next_s = inflight_s ? DRAIN : IDLE;
                end else begin
                    state_next_s = ACTIVE;
                end
            end
            DRAIN: begin
                if (!inflight_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // busy mirrors the state register without a combinational decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != IDLE);
        end
    end

    // Verifier input: granted signature, or zero when nothing is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vf_sig_r <= 32'h0;
        end else if (hs_s) begin
            vf_sig_r <= sel_sig_s;
        end else begin
            vf_sig_r <= 32'h0;
        end
    end

    // Tag pipeline shifts every cycle so the tail lines up with vf_match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= MATCH_LATENCY; k++) begin
                tags_r[k] <= '{valid: 1'b0, id: 3'd0};
            end
        end else begin
            tags_r[0] <= new_tag_s;
            for (int k = 1; k <= MATCH_LATENCY; k++) begin
                tags_r[k] <= tags_r[k-1];
            end
        end
    end

    // Result stage: strobe for one cycle; id and match hold between results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r <= {N_REQ{1'b0}};
            rsp_id_r    <= {ID_W{1'b0}};
            rsp_match_r <= 1'b0;
        end else if (tail_s.valid) begin
            rsp_valid_r <= {{(N_REQ-1){1'b0}}, 1'b1} << tail_s.id;
            rsp_id_r    <= ID_W'(tail_s.id);
            rsp_match_r <= bus.vf_match;
        end else begin
            rsp_valid_r <= {N_REQ{1'b0}};
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_r  <= 16'h0;
            matched_r <= 16'h0;
        end else if (stat_clr) begin
            issued_r  <= 16'h0;
            matched_r <= 16'h0;
        end else begin
            if (hs_s) begin
                issued_r <= sat_inc(issued_r);
            end
            if ((|rsp_valid_r) && rsp_match_r) begin
                matched_r <= sat_inc(matched_r);
            end
        end
    end

endmodule

// File: tb/tb_sig_verify_scheduler.sv
// Bench for sig_verify_scheduler: transaction-level model (queue of issued
// signatures with due cycles) checked every cycle, plus directed scenarios.
module tb_sig_verify_scheduler;
    import sig_sched_pkg::*;

    localparam int N = 4;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        stat_clr;
    logic        busy;
    logic [15:0] stat_issued;
    logic [15:0] stat_matched;

    sig_verify_scheduler_if #(.N_REQ(N)) bus ();

    sig_verify_scheduler #(.N_REQ(N), .MATCH_LATENCY(L)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .stat_clr     (stat_clr),
        .busy         (busy),
        .stat_issued  (stat_issued),
        .stat_matched (stat_matched),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Behavioural verifier: match iff low byte is 8'h42, L cycles after vf_sig.
    logic [31:0] vh1 = 32'h0;
    logic [31:0] vh2 = 32'h0;
    always @(posedge clk) begin
        vh1 <= bus.vf_sig;
        vh2 <= vh1;
    end
    assign bus.vf_match = (vh2[7:0] == 8'h42);

    function automatic logic exp_match(input logic [31:0] s);
        return s[7:0] == 8'h42;
    endfunction

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    typedef struct {
        int          id;
        logic [31:0] sig;
        int          due;
    } txn_t;

    txn_t        q[$];
    int          m_state;
    int          m_last;
    int          cyc;
    logic [31:0] m_vf;
    int          m_issued;
    int          m_matched;
    int          m_rid;
    logic        m_rmatch;

    always @(negedge clk) begin : model
        int          gi;
        int          nxt;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        logic        rsp_now;
        logic [31:0] s;
        if (rst) begin
            q.delete();
            m_state   = 0;
            m_last    = N - 1;
            m_vf      = 32'h0;
            m_issued  = 0;
            m_matched = 0;
            m_rid     = 0;
            m_rmatch  = 1'b0;
            cyc       = 0;
        end else begin
            gi = -1;
            if (m_state == 1 && en) begin
                for (int k = 1; k <= N; k++) begin
                    if (gi < 0 && bus.req_valid[(m_last + k) % N]) gi = (m_last + k) % N;
                end
            end
            exp_rdy = '0;
            if (gi >= 0) exp_rdy[gi] = 1'b1;
            check("busy", busy, m_state != 0);
            check("req_ready", bus.req_ready, exp_rdy);
            check("vf_sig", bus.vf_sig, m_vf);
            rsp_now = 1'b0;
            exp_rv  = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
                rsp_now   = 1'b1;
                m_rid     = q[0].id;
                m_rmatch  = exp_match(q[0].sig);
                exp_rv[m_rid] = 1'b1;
                void'(q.pop_front());
            end
            check("rsp_valid", bus.rsp_valid, exp_rv);
            check("rsp_id", bus.rsp_id, m_rid);
            check("rsp_match", bus.rsp_match, m_rmatch);
            check("stat_issued", stat_issued, m_issued);
            check("stat_matched", stat_matched, m_matched);
            nxt = m_state;
            if (m_state == 0 && en) nxt = 1;
            if (m_state == 1 && !en) nxt = (q.size() > 0) ? 2 : 0;
            if (m_state == 2 && q.size() == 0) nxt = 0;
            if (stat_clr) begin
                m_issued  = 0;
                m_matched = 0;
            end else begin
                if (gi >= 0 && m_issued < 65535) m_issued++;
                if (rsp_now && m_rmatch && m_matched < 65535) m_matched++;
            end
            if (gi >= 0) begin
                s = bus.req_sig[gi*32 +: 32];
                q.push_back('{id: gi, sig: s, due: cyc + 2 + L});
                m_last = gi;
                m_vf   = s;
            end else begin
                m_vf = 32'h0;
            end
            m_state = nxt;
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_sigs(input logic force_match);
        logic [31:0] s;
        for (int i = 0; i < N; i++) begin
            s = $urandom;
            if (force_match || $urandom_range(0, 3) == 0) s[7:0] = 8'h42;
            else if (s[7:0] == 8'h42) s[7:0] = 8'h41;
            bus.req_sig[i*32 +: 32] = s;
        end
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int seen;
        int cnt;
        int last_i;
        int low_i;
        int w;
        rst = 1'b1;
        en = 1'b0;
        stat_clr = 1'b0;
        bus.req_valid = '0;
        bus.req_sig = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_vf_sig", bus.vf_sig, 32'h0);
        check("reset_rsp_valid", bus.rsp_valid, 4'b0000);
        check("reset_stat_issued", stat_issued, 16'h0);

        // Full contention: grants rotate 0..3 twice, results return in order
        tick(); en = 1'b1;
        tick();
        bus.req_valid = 4'hF;
        rand_sigs(1'b0);
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i < 8) check("contention_grant", bus.req_ready, 4'b0001 << (i % 4));
            if (|bus.rsp_valid) begin
                check("contention_rsp_order", bus.rsp_id, seen % 4);
                seen++;
            end
            tick();
            if (i == 7) bus.req_valid = '0;
            else rand_sigs(1'b0);
        end
        check("contention_rsp_count", seen, 8);
        check("contention_issued", stat_issued, 16'd8);

        // Single request from requester 2
        stat_clr = 1'b1;
        tick(); stat_clr = 1'b0;
        bus.req_valid = 4'b0100;
        bus.req_sig[2*32 +: 32] = 32'hA5031042;
        @(negedge clk);
        check("single_ready", bus.req_ready, 4'b0100);
        tick(); bus.req_valid = '0;
        @(negedge clk);
        check("single_vf_sig", bus.vf_sig, 32'hA5031042);
        repeat (3) @(negedge clk);
        check("single_rsp_valid", bus.rsp_valid, 4'b0100);
        check("single_rsp_id", bus.rsp_id, 2);
        check("single_rsp_match", bus.rsp_match, 1'b1);
        repeat (2) @(negedge clk);
        check("single_stat_issued", stat_issued, 16'd1);
        check("single_stat_matched", stat_matched, 16'd1);

        // Drain with two tags in flight; en re-raised during DRAIN
        tick(); bus.req_valid = 4'b0010;
        tick(); bus.req_valid = 4'b0100;
        tick(); en = 1'b0; bus.req_valid = 4'hF;
        @(negedge clk);
        check("drain_ready_blocked", bus.req_ready, 4'b0000);
        tick(); en = 1'b1;
        cnt = 0; last_i = -100; low_i = -1000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (|bus.rsp_valid) begin
                cnt++;
                last_i = i;
            end
            if (!busy) begin
                low_i = i;
                break;
            end
            check("drain_no_grant", bus.req_ready, 4'b0000);
        end
        check("drain_rsp_count", cnt, 2);
        check("drain_busy_fall", low_i - last_i, 1);
        tick(); bus.req_valid = '0;

        // Reset with three tags in flight
        tick(); tick();
        bus.req_valid = 4'hF;
        rand_sigs(1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1; bus.req_valid = '0; en = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 4'b0000);
        check("rst_vf_sig", bus.vf_sig, 32'h0);
        check("rst_stat_issued", stat_issued, 16'h0);
        check("rst_rsp_id", bus.rsp_id, 0);
        tick(); rst = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (|bus.rsp_valid) cnt++;
        end
        check("rst_no_rsp_after", cnt, 0);

        // Fairness: requester 0 always valid, requester 3 pulses
        tick(); en = 1'b1;
        tick(); tick();
        bus.req_valid = 4'b0001;
        for (int it = 0; it < 10; it++) begin
            repeat ($urandom_range(0, 3)) tick();
            bus.req_valid[3] = 1'b1;
            w = 0;
            for (int t = 0; t < 6; t++) begin
                @(negedge clk);
                if (bus.req_ready[3]) break;
                w++;
                tick();
            end
            check("fair_wait_within_2", (w <= 1), 1'b1);
            tick(); bus.req_valid[3] = 1'b0;
        end
        bus.req_valid = '0;

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            tick();
            en = ($urandom_range(0, 7) != 0);
            bus.req_valid = N'($urandom);
            stat_clr = ($urandom_range(0, 31) == 0);
            rand_sigs(1'b0);
        end
        tick();
        en = 1'b1; bus.req_valid = '0; stat_clr = 1'b0;
        repeat (10) tick();

        // Saturation: 65537 matching signatures, then clear with a handshake
        stat_clr = 1'b1;
        tick(); stat_clr = 1'b0;
        bus.req_valid = 4'b0001;
        rand_sigs(1'b1);
        repeat (65537) begin
            tick();
            rand_sigs(1'b1);
        end
        bus.req_valid = '0;
        repeat (8) @(negedge clk);
        check("sat_issued", stat_issued, 16'hFFFF);
        check("sat_matched", stat_matched, 16'hFFFF);
        tick();
        bus.req_valid = 4'b0001; stat_clr = 1'b1;
        @(negedge clk);
        check("clr_hs_ready", bus.req_ready, 4'b0001);
        tick(); bus.req_valid = '0; stat_clr = 1'b0;
        @(negedge clk);
        check("clr_issued", stat_issued, 16'h0);
        check("clr_matched", stat_matched, 16'h0);
        repeat (8) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
